// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the uart byte-side echo responder.
//                Holds the data width and the receive/transmit FSM encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int BYTE_W = 8;

    // Receive handshake FSM: accept a byte, then wait for rdy to drop.
    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_CLR  = 1'b1
    } rx_state_t;

    // Transmit FSM: pop, strobe the uart, follow its busy flag.
    typedef enum logic [1:0] {
        T_IDLE      = 2'd0,
        T_LOAD      = 2'd1,
        T_WAIT_BUSY = 2'd2,
        T_WAIT_DONE = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo
//  Description : Single-clock byte FIFO with registered occupancy.
//                Ports: clk, rst (async, active-high), push/wdata (write side),
//                pop/rdata (read side, rdata is the current head), full,
//                empty, level (occupancy 0..DEPTH).
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [BYTE_W-1:0]        wdata,
    output logic [BYTE_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL_LVL = (c_PTR_W + 1)'(DEPTH);

    logic [BYTE_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_level;
    logic               w_do_push;
    logic               w_do_pop;

    assign full  = (r_level == c_FULL_LVL);
    assign empty = (r_level == '0);
    assign level = r_level;
    assign rdata = r_mem[r_rd_ptr];

    // A write into a full FIFO only fits if the head leaves in the same cycle.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (c_PTR_W + 1)'(1);
                2'b01:   r_level <= r_level - (c_PTR_W + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_echo_responder.sv
`default_nettype none
// ============================================================================
//  Module      : uart_echo_responder
//  Description : Byte-side far end of the uart. Accepts received bytes
//                (rdy/dout, acknowledged by rdy_clr), queues them and echoes
//                each one XOR XOR_MASK through the transmitter (din/wr_en,
//                paced by tx_busy).
//                Ports: clk_50m, rst (async, active-high), rdy, dout, rdy_clr,
//                tx_busy, din, wr_en, level (FIFO occupancy), overflow
//                (sticky drop flag), drop_cnt (saturating drop count).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_echo_responder
    import uart_pkg::*;
#(
    parameter int                DEPTH        = 8,
    parameter logic [BYTE_W-1:0] XOR_MASK     = 8'h00,
    parameter int                BUSY_TIMEOUT = 16
) (
    input  logic                     clk_50m,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic [BYTE_W-1:0]        dout,
    output logic                     rdy_clr,
    input  logic                     tx_busy,
    output logic [BYTE_W-1:0]        din,
    output logic                     wr_en,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int               c_TMO_W   = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(BUSY_TIMEOUT - 1);

    rx_state_t          r_rx_state;
    tx_state_t          r_tx_state;
    logic               r_rdy_clr;
    logic               r_overflow;
    logic [7:0]         r_drop_cnt;
    logic [BYTE_W-1:0]  r_hold;
    logic [BYTE_W-1:0]  r_din;
    logic               r_wr_en;
    logic [c_TMO_W-1:0] r_tmo_cnt;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [BYTE_W-1:0]  w_rdata;

    // Only the first cycle of an rdy assertion can push; R_CLR blocks repeats.
    assign w_push = (r_rx_state == R_IDLE) & rdy & ~w_full;
    assign w_pop  = (r_tx_state == T_IDLE) & ~w_empty & ~tx_busy;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_50m),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (dout),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

    // ---------------- receive handshake ----------------
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_rx_state <= R_IDLE;
            r_rdy_clr  <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'h00;
        end else begin
            r_rdy_clr <= 1'b0;
            case (r_rx_state)
                R_IDLE: begin
                    if (rdy) begin
                        // A dropped byte is still acknowledged so the uart can move on.
                        r_rdy_clr  <= 1'b1;
                        r_rx_state <= R_CLR;
                        if (w_full) begin
                            r_overflow <= 1'b1;
                            if (r_drop_cnt != 8'hFF) begin
                                r_drop_cnt <= r_drop_cnt + 8'd1;
                            end
                        end
                    end
                end
                R_CLR: begin
                    if (!rdy) begin
                        r_rx_state <= R_IDLE;
                    end
                end
                default: r_rx_state <= R_IDLE;
            endcase
        end
    end

    // ---------------- transmit sequencing ----------------
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_tx_state <= T_IDLE;
            r_hold     <= '0;
            r_din      <= '0;
            r_wr_en    <= 1'b0;
            r_tmo_cnt  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_tx_state)
                T_IDLE: begin
                    if (w_pop) begin
                        r_hold     <= w_rdata;
                        r_tx_state <= T_LOAD;
                    end
                end
                T_LOAD: begin
                    r_din      <= r_hold ^ XOR_MASK;
                    r_wr_en    <= 1'b1;
                    r_tmo_cnt  <= '0;
                    r_tx_state <= T_WAIT_BUSY;
                end
                T_WAIT_BUSY: begin
                    // A transmitter that never reacts must not stall the echo path.
                    if (tx_busy) begin
                        r_tx_state <= T_WAIT_DONE;
                    end else if (r_tmo_cnt == c_TMO_LAST) begin
                        r_tx_state <= T_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
                    end
                end
                T_WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_tx_state <= T_IDLE;
                    end
                end
                default: r_tx_state <= T_IDLE;
            endcase
        end
    end

    assign rdy_clr  = r_rdy_clr;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;
    assign din      = r_din;
    assign wr_en    = r_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_echo_responder
//  Description : Self-checking bench for uart_echo_responder. Models the
//                uart receive side (rdy/dout, cleared by rdy_clr) and the
//                transmitter busy flag; expected echo bytes are queued when a
//                byte is offered and compared whenever wr_en fires.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_echo_responder;

    localparam int         DEPTH        = 8;
    localparam logic [7:0] XOR_MASK     = 8'h20;
    localparam int         BUSY_TIMEOUT = 16;

    localparam int TX_NORMAL = 0;
    localparam int TX_HOLD   = 1;
    localparam int TX_NEVER  = 2;

    logic                   clk_50m = 1'b0;
    logic                   rst     = 1'b1;
    logic                   rdy     = 1'b0;
    logic [7:0]             dout    = 8'h00;
    logic                   tx_busy = 1'b0;
    logic                   rdy_clr;
    logic [7:0]             din;
    logic                   wr_en;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;
    logic [7:0]             drop_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    int          cyc = 0;
    int          wr_cnt = 0;
    int          clr_cnt = 0;
    int          last_wr_cyc = 0;
    int          prev_wr_cyc = 0;
    int          sent_cyc = 0;
    int          tx_mode = TX_NORMAL;
    int          busy_len = 4;
    int          busy_left = 0;

    uart_echo_responder #(
        .DEPTH        (DEPTH),
        .XOR_MASK     (XOR_MASK),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk_50m  (clk_50m),
        .rst      (rst),
        .rdy      (rdy),
        .dout     (dout),
        .rdy_clr  (rdy_clr),
        .tx_busy  (tx_busy),
        .din      (din),
        .wr_en    (wr_en),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #10 clk_50m = ~clk_50m;

    always @(posedge clk_50m) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard plus transmitter model, evaluated away from the active edge.
    always @(negedge clk_50m) begin
        if (rdy_clr) clr_cnt++;
        if (wr_en) begin
            wr_cnt++;
            prev_wr_cyc = last_wr_cyc;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_wr_en", 32'(din), 32'hFFFF_FFFF);
            end else begin
                chk("echo_din", 32'(din), 32'(exp_q.pop_front()));
            end
        end
        case (tx_mode)
            TX_HOLD: begin
                tx_busy   = 1'b1;
                busy_left = 0;
            end
            TX_NEVER: begin
                tx_busy   = 1'b0;
                busy_left = 0;
            end
            default: begin
                if (busy_left > 0) busy_left--;
                tx_busy = (busy_left > 0);
                if (wr_en) begin
                    tx_busy   = 1'b1;
                    busy_left = busy_len;
                end
            end
        endcase
    end

    // Offer one byte the way the uart does: rdy stays up until rdy_clr.
    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk_50m);
        rdy      = 1'b1;
        dout     = b;
        sent_cyc = cyc;
        n = 0;
        do begin
            @(negedge clk_50m);
            n++;
        end while (!rdy_clr && n < 10);
        if (!rdy_clr) chk("rdy_clr_timeout", 32'(n), 32'd0);
        rdy = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk_50m);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (6) @(negedge clk_50m);
    endtask

    typedef struct {
        logic [7:0] rx_byte;
        logic [7:0] exp_din;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int clr0;
        int wr0;

        vecs[0] = '{8'h61, 8'h41};
        vecs[1] = '{8'hA5, 8'h85};
        vecs[2] = '{8'h00, 8'h20};
        vecs[3] = '{8'hFF, 8'hDF};
        vecs[4] = '{8'h20, 8'h00};
        vecs[5] = '{8'h5A, 8'h7A};

        // Reset state
        repeat (3) @(negedge clk_50m);
        chk("rst_rdy_clr", 32'(rdy_clr), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_din", 32'(din), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk_50m);

        // Minimum latency: rdy sampled to wr_en visible is three clocks.
        exp_q.push_back(8'hC4);
        send_byte(8'hE4);
        wait_drain(50);
        chk("latency", 32'(last_wr_cyc - sent_cyc), 32'd3);

        // Table of single-byte echoes through the mask
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i].exp_din);
            send_byte(vecs[i].rx_byte);
            wait_drain(50);
            chk("level_after_echo", 32'(level), 32'd0);
        end

        // Overflow: transmitter stuck busy, nine bytes into an eight-deep FIFO
        tx_mode = TX_HOLD;
        repeat (3) @(negedge clk_50m);
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) exp_q.push_back(8'(i) ^ 8'h20);
            send_byte(8'(i));
        end
        repeat (2) @(negedge clk_50m);
        chk("ovf_level", 32'(level), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
        tx_mode = TX_NORMAL;
        wait_drain(300);
        chk("ovf_level_drained", 32'(level), 32'd0);
        chk("ovf_flag_sticky", 32'(overflow), 32'd1);

        // rdy held high for 20 cycles: one push, one rdy_clr pulse
        clr0 = clr_cnt;
        wr0  = wr_cnt;
        exp_q.push_back(8'h13);
        @(negedge clk_50m);
        rdy  = 1'b1;
        dout = 8'h33;
        repeat (20) @(negedge clk_50m);
        rdy = 1'b0;
        wait_drain(50);
        chk("hold_rdy_clr_pulses", 32'(clr_cnt - clr0), 32'd1);
        chk("hold_rdy_wr_count", 32'(wr_cnt - wr0), 32'd1);

        // Transmitter never goes busy: 16 waiting cycles, then an idle pop
        // cycle and a load cycle before the next strobe.
        tx_mode = TX_NEVER;
        repeat (2) @(negedge clk_50m);
        exp_q.push_back(8'h64);
        send_byte(8'h44);
        exp_q.push_back(8'h75);
        send_byte(8'h55);
        wait_drain(100);
        chk("timeout_interval", 32'(last_wr_cyc - prev_wr_cyc), 32'(BUSY_TIMEOUT + 2));

        // Reset while waiting for the transmitter with three bytes queued
        tx_mode  = TX_NORMAL;
        busy_len = 100;
        repeat (2) @(negedge clk_50m);
        exp_q.push_back(8'h30);
        send_byte(8'h10);
        send_byte(8'h11);
        send_byte(8'h12);
        send_byte(8'h13);
        repeat (2) @(negedge clk_50m);
        chk("pre_rst_level", 32'(level), 32'd3);
        chk("pre_rst_wr_count", 32'(exp_q.size()), 32'd0);
        wr0 = wr_cnt;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_din", 32'(din), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        chk("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        repeat (2) @(negedge clk_50m);
        rst = 1'b0;
        busy_len = 4;
        repeat (150) @(negedge clk_50m);
        chk("post_rst_no_wr_en", 32'(wr_cnt - wr0), 32'd0);
        chk("post_rst_level", 32'(level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
